// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    localparam int STALL_W = 16;

    // Index width for n items; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo NREQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int  NREQ = 4,
    localparam int IDW  = clog2_min1(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [IDW-1:0]  idx
);

    logic [NREQ-1:0] w_rot;
    logic [IDW-1:0]  w_off;
    logic            w_hit;
    int              w_j;
    int              w_sum;

    // Rotate the request vector so that position ptr lands on bit 0.
    always_comb begin
        w_rot = '0;
        w_j   = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_j      = (i + int'(ptr)) % NREQ;
            w_rot[i] = req[w_j[IDW-1:0]];
        end
    end

    // Priority-encode the rotated vector, lowest bit wins.
    always_comb begin
        w_off = '0;
        w_hit = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_hit && w_rot[i]) begin
                w_hit = 1'b1;
                w_off = IDW'(i);
            end
        end
    end

    // Undo the rotation to get the absolute requester index.
    always_comb begin
        w_sum = int'(w_off) + int'(ptr);
        if (w_sum >= NREQ) begin
            w_sum = w_sum - NREQ;
        end
        idx = w_sum[IDW-1:0];
        any = |req;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ requesters.
// Writes are gated combinationally by wfull so a full FIFO is never written.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  DSIZE    = 8,
    parameter int  NREQ     = 4,
    parameter int  MAXBURST = 4,
    localparam int IDW      = clog2_min1(NREQ)
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       ack,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [IDW-1:0]        gnt_id,
    output logic                  busy,
    output logic [STALL_W-1:0]    stall_cnt
);

    localparam int            BW        = clog2_min1(MAXBURST);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAXBURST - 1);

    arb_state_t         r_state;
    logic [IDW-1:0]     r_gnt_id;
    logic [IDW-1:0]     r_ptr;
    logic [BW-1:0]      r_beat_cnt;
    logic [STALL_W-1:0] r_stall_cnt;

    logic               w_any;
    logic [IDW-1:0]     w_idx;
    logic               w_busy;
    logic               w_sel_req;
    logic               w_accept;
    logic [IDW-1:0]     w_ptr_nxt;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req (req),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    // Grant-holder view of the request and the accept decision.
    always_comb begin
        w_busy    = (r_state == ST_BURST);
        w_sel_req = req[r_gnt_id];
        w_accept  = w_busy & w_sel_req & ~wfull;
        w_ptr_nxt = (int'(r_gnt_id) == NREQ - 1) ? '0 : r_gnt_id + 1'b1;
    end

    // Output muxing; everything is zero outside a burst.
    always_comb begin
        ack   = '0;
        wdata = '0;
        winc  = w_accept;
        if (w_accept) begin
            ack[r_gnt_id] = 1'b1;
        end
        if (w_busy) begin
            wdata = req_data[int'(r_gnt_id)*DSIZE +: DSIZE];
        end
    end

    // Arbitration FSM with burst and back-pressure counters.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_state     <= ST_IDLE;
            r_gnt_id    <= '0;
            r_ptr       <= '0;
            r_beat_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt_id   <= w_idx;
                        r_beat_cnt <= '0;
                        r_state    <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (!w_sel_req) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= w_ptr_nxt;
                    end else if (wfull) begin
                        // Full cycles hold the grant and do not spend burst budget.
                        if (r_stall_cnt != '1) begin
                            r_stall_cnt <= r_stall_cnt + 1'b1;
                        end
                    end else if (r_beat_cnt == LAST_BEAT) begin
                        r_beat_cnt <= '0;
                        r_state    <= ST_IDLE;
                        r_ptr      <= w_ptr_nxt;
                    end else begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt_id    = r_gnt_id;
    assign busy      = w_busy;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random
// traffic, all checked cycle by cycle against a behavioural model.
module tb_fifo_wr_arbiter;

    localparam int NREQ     = 4;
    localparam int DSIZE    = 8;
    localparam int MAXBURST = 4;

    logic        wclk = 1'b0;
    logic        wrst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        wfull;
    logic        winc;
    logic [7:0]  wdata;
    logic [1:0]  gnt_id;
    logic        busy;
    logic [15:0] stall_cnt;

    logic [7:0]  dat [4];

    fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .MAXBURST(MAXBURST)) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    always #5 wclk = ~wclk;
    assign req_data = {dat[3], dat[2], dat[1], dat[0]};

    // reference model: who holds the grant, beats taken, where search starts
    int m_busy, m_h, m_next, m_taken, m_stall;
    int n_cmp, n_err;
    bit seq_mode;

    // observations of the last stepped cycle
    logic       o_winc;
    logic [3:0] o_ack;
    logic [7:0] o_wdata;
    int         o_h;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_h = 0; m_next = 0; m_taken = 0; m_stall = 0;
    endtask

    task automatic do_reset();
        wrst = 1'b1; req = '0; wfull = 1'b0;
        @(posedge wclk); #1;
        wrst = 1'b0;
        model_reset();
    endtask

    // One clock: drive inputs, check outputs mid-cycle, advance the model.
    task automatic step(input logic [3:0] rq, input logic wf);
        logic       ew;
        logic [3:0] ea;
        logic [7:0] ed;
        int         j;
        bit         found;
        req = rq; wfull = wf;
        @(negedge wclk);
        ew = 1'b0; ea = '0; ed = '0;
        if (m_busy != 0) begin
            ew = rq[m_h] & ~wf;
            ea = ew ? (4'b0001 << m_h) : 4'b0000;
            ed = dat[m_h];
        end
        chk("winc",  winc,  ew);
        chk("ack",   ack,   ea);
        chk("wdata", wdata, ed);
        chk("busy",  busy,  (m_busy != 0));
        chk("gnt",   gnt_id, m_h);
        chk("stall", stall_cnt, m_stall);
        o_winc = winc; o_ack = ack; o_wdata = wdata; o_h = m_h;
        if (m_busy == 0) begin
            found = 0;
            for (int k = 0; k < NREQ; k++) begin
                j = (m_next + k) % NREQ;
                if (!found && rq[j]) begin
                    found = 1; m_busy = 1; m_h = j; m_taken = 0;
                end
            end
        end else if (!rq[m_h]) begin
            m_busy = 0; m_next = (m_h + 1) % NREQ;
        end else if (wf) begin
            if (m_stall < 65535) m_stall++;
        end else begin
            m_taken++;
            if (m_taken == MAXBURST) begin
                m_busy = 0; m_next = (m_h + 1) % NREQ;
            end
        end
        @(posedge wclk); #1;
        if (ew) dat[o_h] = seq_mode ? dat[o_h] + 8'd1 : 8'($urandom);
    endtask

    logic [7:0] wq[$];
    int         gq[$];
    int         acks[$];
    logic [9:0] wpat;
    logic [3:0] rq;
    logic       pb;
    int         nack;

    initial begin
        n_cmp = 0; n_err = 0; seq_mode = 1'b0;
        for (int i = 0; i < 4; i++) dat[i] = 8'h00;
        wrst = 1'b1; req = '0; wfull = 1'b0;
        #2;
        chk("rst_winc", winc, 0);
        chk("rst_busy", busy, 0);
        do_reset();
        chk("rst_gnt",   gnt_id, 0);
        chk("rst_stall", stall_cnt, 0);

        // single requester, sequential data
        seq_mode = 1'b1; dat[1] = 8'h10; wq.delete();
        for (int c = 0; c < 10; c++) begin
            step(4'b0010, 1'b0);
            wpat[9-c] = o_winc;
            if (o_winc) wq.push_back(o_wdata);
        end
        chk("single_pat", wpat, 10'b0_1111_0_1111);
        chk("single_cnt", wq.size(), 8);
        for (int i = 0; i < wq.size(); i++) chk("single_data", wq[i], 8'h10 + i);
        chk("single_gnt", gnt_id, 1);

        // round robin with everyone requesting
        do_reset(); gq.delete(); acks.delete(); pb = 1'b0; nack = 0;
        for (int c = 0; c < 24; c++) begin
            step(4'b1111, 1'b0);
            if (o_winc) nack++;
            if (busy && !pb) gq.push_back(int'(gnt_id));
            if (!busy && pb) begin acks.push_back(nack); nack = 0; end
            pb = busy;
        end
        chk("rr_ngnt", gq.size() >= 5, 1);
        for (int i = 0; i < 5 && i < gq.size(); i++) chk("rr_order", gq[i], i % 4);
        chk("rr_nburst", acks.size() >= 4, 1);
        for (int i = 0; i < acks.size(); i++) chk("rr_acks", acks[i], 4);

        // early drop, next requester waiting
        seq_mode = 1'b0;
        do_reset();
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b1000, 1'b0);
        chk("drop_idle", busy, 0);
        step(4'b1000, 1'b0);
        chk("drop_gnt3", gnt_id, 3);
        // early drop, nobody above: wraps to 0
        do_reset();
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        chk("drop_gnt0", gnt_id, 0);

        // back-pressure mid-burst
        do_reset(); seq_mode = 1'b1; dat[0] = 8'hA0; wq.delete();
        step(4'b0001, 1'b0);
        for (int c = 0; c < 2; c++) begin
            step(4'b0001, 1'b0); if (o_winc) wq.push_back(o_wdata);
        end
        for (int c = 0; c < 5; c++) begin
            step(4'b0001, 1'b1);
            chk("bp_winc", o_winc, 0);
            chk("bp_ack",  o_ack, 0);
        end
        for (int c = 0; c < 3; c++) begin
            step(4'b0001, 1'b0); if (o_winc) wq.push_back(o_wdata);
        end
        chk("bp_stall", stall_cnt, 5);
        chk("bp_beats", wq.size(), 4);
        for (int i = 0; i < wq.size(); i++) chk("bp_data", wq[i], 8'hA0 + i);

        // asynchronous reset in the middle of a burst
        do_reset(); seq_mode = 1'b0;
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b1);
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        req = 4'b0010; wfull = 1'b0;
        #2;
        chk("pre_rst_winc", winc, 1);
        wrst = 1'b1;
        #1;
        chk("mid_rst_winc",  winc, 0);
        chk("mid_rst_ack",   ack, 0);
        chk("mid_rst_busy",  busy, 0);
        chk("mid_rst_wdata", wdata, 0);
        @(posedge wclk); #1;
        wrst = 1'b0; req = '0;
        model_reset();
        #1;
        chk("post_rst_gnt",   gnt_id, 0);
        chk("post_rst_stall", stall_cnt, 0);

        // random traffic under the requester hold rule
        do_reset(); seq_mode = 1'b0; rq = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (rq[i]) begin
                    if (o_ack[i]) rq[i] = ($urandom_range(9) < 7);
                    else if ($urandom_range(49) == 0) rq[i] = 1'b0;
                end else begin
                    rq[i] = ($urandom_range(9) < 4);
                    if (rq[i]) dat[i] = 8'($urandom);
                end
            end
            step(rq, ($urandom_range(9) < 2));
        end

        // stall counter saturation
        do_reset(); o_ack = '0;
        for (int c = 0; c < 70000; c++) step(4'b0001, 1'b1);
        chk("sat_stall", stall_cnt, 16'hFFFF);
        step(4'b0001, 1'b1);
        step(4'b0001, 1'b1);
        chk("sat_hold", stall_cnt, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one write port of the async FIFO between NREQ requesters in the write clock domain. It grants one requester at a time for a bounded burst and drives `winc`/`wdata` into the FIFO. It honours `wfull` with a valid/ready handshake per requester and counts cycles lost to back-pressure. It sits directly in front of the FIFO write side, between the producer blocks and the FIFO.

## Interface
- `DSIZE`, 8, data width; matches the FIFO data bus.
- `NREQ`, 4, number of requesters, ≥1.
- `MAXBURST`, 4, maximum accepted beats per grant, ≥1.
- `IDW`, `$clog2(NREQ)` (min 1), width of the grant index; derived, not overridden.

Ports:
- `wclk`  in  1  write-domain clock; all state on rising edge.
- `wrst`  in  1  reset, asynchronous, active-high.
- `req`  in  NREQ  per-requester valid; bit i = requester i.
- `req_data`  in  NREQ*DSIZE  requester i data at bits [i*DSIZE +: DSIZE].
- `ack`  out  NREQ  per-requester ready/accept; one-hot or zero.
- `wfull`  in  1  FIFO full flag, `wclk` domain.
- `winc`  out  1  FIFO write enable.
- `wdata`  out  DSIZE  FIFO write data.
- `gnt_id`  out  IDW  index of the current grant holder.
- `busy`  out  1  a grant is active (state BURST).
- `stall_cnt`  out  16  saturating count of back-pressure cycles.

## Operation
- State machine has two states: IDLE and BURST.
- Registers: `state`, `gnt_id`, `ptr` (round-robin start, IDW bits), `beat_cnt` (wide enough for MAXBURST-1), `stall_cnt`.
- **IDLE:**
  - If `|req`, pick the first set bit at or after `ptr`, searching upward and wrapping modulo NREQ.
  - Load `gnt_id` with that index, clear `beat_cnt`, and go to BURST.
  - Otherwise stay in IDLE.
- **BURST:**
  - `winc = req[gnt_id] & ~wfull`.
  - `ack[gnt_id] = winc`; all other `ack` bits are 0.
  - `wdata` = the `req_data` slice of `gnt_id`.
  - On an accepted beat, `beat_cnt` increments.
- **Leave BURST → IDLE** on either condition:
  - an accepted beat with `beat_cnt == MAXBURST-1`, or
  - `req[gnt_id]` low in a cycle (no write that cycle).
- On leaving BURST, `ptr <= (gnt_id+1) mod NREQ`. This gives fair rotation even if the same requester still asserts `req`.
- **Back-pressure:**
  - When `req[gnt_id] & wfull` in BURST, `stall_cnt` increments, saturating at 16'hFFFF.
  - The grant is held and `beat_cnt` is frozen; full cycles do not consume burst budget.
- **Requester rule:** once `req[i]` is raised, hold it and its data stable until `ack[i]`. Dropping `req` before `ack` is legal but ends that requester's burst.
- In IDLE: `winc=0`, `ack=0`, `wdata=0`.
- `busy = (state==BURST)`.
- **Reset (async, any time, including mid-burst):**
  - `state=IDLE`, `gnt_id=0`, `ptr=0`, `beat_cnt=0`, `stall_cnt=0`.
  - Hence `winc=0`, `ack=0`, `wdata=0`, `busy=0` immediately, with no clock needed.
  - An in-flight beat that was not acked is not written.
- NREQ=1: `ptr` and `gnt_id` stay 0; bursts are still capped at MAXBURST with an IDLE bubble between them.

## Timing
- Arbitration latency: `req` first sampled high in IDLE at edge t → `busy`/`gnt_id` valid after t. The first possible `winc`/`ack` is in cycle t+1 (combinational from state).
- One idle bubble cycle between consecutive grants.
- Combinational paths are `wfull`/`req`/`req_data` → `winc`, `ack`, `wdata`. There is no registered output stage, so a write is never issued into a full FIFO.
- `wfull` must already be synchronous to `wclk`; this block adds no synchronizers.
- Peak throughput is MAXBURST beats per MAXBURST+1 cycles under continuous requests with `wfull=0`.

## Structure
- Shared package `fifo_arb_pkg`:
  - state encoding constants `ST_IDLE=1'b0`, `ST_BURST=1'b1`;
  - `STALL_W=16`;
  - a clog2 helper function for IDW.
- One sub-module, `rr_pick`: purely combinational, parameter NREQ.
  - Inputs: `req[NREQ]`, `ptr[IDW]`.
  - Outputs: `any`, `idx[IDW]`.
  - Rotate, priority-encode, un-rotate.
- Top level holds the FSM, counters and output muxing.

## Test plan
- **Reset:** assert `wrst` mid-burst (requester 1, `beat_cnt`=2) → `winc`, `ack`, `busy` go 0 within the same cycle; after release, `gnt_id=0` and `stall_cnt=0`.
- **Single requester:** `req=4'b0010` held, data 8'h10..8'h17, `wfull=0` → 8 writes in order. Timing: 4 beats, 1 IDLE cycle, 4 beats; `gnt_id=1` throughout.
- **Round-robin:** `req=4'b1111` continuous, MAXBURST=4, `wfull=0` → grant order 0,1,2,3,0. Each grant gives exactly 4 acks, then one bubble.
- **Early drop:** requester 2 drops `req` after 2 acks → return to IDLE; next grant goes to requester 3 if requesting, else wraps to 0.
- **Back-pressure:** requester 0 bursting, `wfull` high for 5 cycles mid-burst → `winc=0` and `ack=0` for those 5 cycles; `stall_cnt` +5; burst still totals 4 accepted beats; no data lost or duplicated against the FIFO read-back.
- **Saturation:** force 70000 stall cycles → `stall_cnt` holds 16'hFFFF and does not wrap.
